// File: rtl/axi_motor_pkg.sv
// Shared constants and helpers for the motor AXI4-Lite slave: register indices,
// CTRL bit positions, response codes, byte-lane merge and quadrature decode.
package axi_motor_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_DUTY   = 2'd2;
  localparam logic [1:0] REG_ENC    = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_DIR_BIT   = 1;
  localparam int CTRL_BRAKE_BIT = 2;
  localparam int CTRL_WIDTH     = 3;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // States are {a,b}; forward Gray order is 00->01->11->10->00.
  function automatic logic [31:0] enc_delta(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: return 32'h0000_0001;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: return 32'hFFFF_FFFF;
      default:                                return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/axi_motor_pwm_gen.sv
// PWM generator with shadowed PERIOD/DUTY that only take effect at a period wrap,
// so software updates never produce a truncated or runt pulse.
module axi_motor_pwm_gen (
  input  logic        clk,
  input  logic        srst,
  input  logic        enable,
  input  logic        brake,
  input  logic [31:0] period,
  input  logic [31:0] duty,
  output logic        pwm_out
);

  logic [31:0] period_sh_reg;
  logic [31:0] duty_sh_reg;
  logic [31:0] cnt_reg;
  logic        pwm_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      period_sh_reg <= '0;
      duty_sh_reg   <= '0;
      cnt_reg       <= '0;
      pwm_reg       <= 1'b0;
    end else if (!enable || period_sh_reg == '0) begin
      // Idle: keep the shadows tracking so the first enabled period uses fresh values.
      period_sh_reg <= period;
      duty_sh_reg   <= duty;
      cnt_reg       <= '0;
      pwm_reg       <= 1'b0;
    end else begin
      pwm_reg <= !brake && (cnt_reg < duty_sh_reg);
      if (cnt_reg == period_sh_reg - 32'd1) begin
        cnt_reg       <= '0;
        period_sh_reg <= period;
        duty_sh_reg   <= duty;
      end else begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign pwm_out = pwm_reg;

endmodule

// File: rtl/axi_motor_lite_slave.sv
// AXI4-Lite slave for the crane motor: CTRL/PERIOD/DUTY/ENC register map,
// quadrature encoder counter and the PWM/direction/brake driver pins.
module axi_motor_lite_slave
  import axi_motor_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_ENC_SYNC_STAGES  = 2
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              enc_a,
  input  logic                              enc_b,
  output logic                              pwm_out,
  output logic                              dir_out,
  output logic                              brake_out
);

  logic                  aw_ready_reg;
  logic                  b_valid_reg;
  logic                  ar_ready_reg;
  logic                  r_valid_reg;
  logic [31:0]           r_data_reg;
  logic [CTRL_WIDTH-1:0] ctrl_reg;
  logic [31:0]           period_reg;
  logic [31:0]           duty_reg;
  logic [31:0]           enc_cnt_reg;
  logic [C_ENC_SYNC_STAGES-1:0] sync_a_reg;
  logic [C_ENC_SYNC_STAGES-1:0] sync_b_reg;
  logic [1:0]            enc_prev_reg;
  logic [1:0]            enc_cur;
  logic [1:0]            wr_sel;
  logic                  wr_en;
  logic                  rd_en;
  logic [31:0]           rd_data;
  logic                  unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // READY is a one-cycle registered pulse, so the handshake edge is the cycle it is high.
  assign wr_en  = aw_ready_reg && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en  = ar_ready_reg && S_AXI_ARVALID;
  assign wr_sel = S_AXI_AWADDR[3:2];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_ready_reg <= 1'b0;
      b_valid_reg  <= 1'b0;
      ar_ready_reg <= 1'b0;
      r_valid_reg  <= 1'b0;
      r_data_reg   <= '0;
    end else begin
      aw_ready_reg <= !aw_ready_reg && S_AXI_AWVALID && S_AXI_WVALID && !b_valid_reg;
      if (wr_en)             b_valid_reg <= 1'b1;
      else if (S_AXI_BREADY) b_valid_reg <= 1'b0;
      ar_ready_reg <= !ar_ready_reg && S_AXI_ARVALID && !r_valid_reg;
      if (rd_en) begin
        r_valid_reg <= 1'b1;
        r_data_reg  <= rd_data;
      end else if (S_AXI_RREADY) begin
        r_valid_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (S_AXI_ARADDR[3:2])
      REG_CTRL:   rd_data = {{(32-CTRL_WIDTH){1'b0}}, ctrl_reg};
      REG_PERIOD: rd_data = period_reg;
      REG_DUTY:   rd_data = duty_reg;
      default:    rd_data = enc_cnt_reg;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_reg   <= '0;
      period_reg <= '0;
      duty_reg   <= '0;
    end else if (wr_en) begin
      if (wr_sel == REG_CTRL && S_AXI_WSTRB[0]) ctrl_reg <= S_AXI_WDATA[CTRL_WIDTH-1:0];
      if (wr_sel == REG_PERIOD) period_reg <= strb_merge(period_reg, S_AXI_WDATA, S_AXI_WSTRB);
      if (wr_sel == REG_DUTY)   duty_reg   <= strb_merge(duty_reg, S_AXI_WDATA, S_AXI_WSTRB);
    end
  end

  assign enc_cur = {sync_a_reg[C_ENC_SYNC_STAGES-1], sync_b_reg[C_ENC_SYNC_STAGES-1]};

  // A software clear takes priority over a simultaneous encoder step.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sync_a_reg   <= '0;
      sync_b_reg   <= '0;
      enc_prev_reg <= 2'b00;
      enc_cnt_reg  <= '0;
    end else begin
      sync_a_reg   <= {sync_a_reg[C_ENC_SYNC_STAGES-2:0], enc_a};
      sync_b_reg   <= {sync_b_reg[C_ENC_SYNC_STAGES-2:0], enc_b};
      enc_prev_reg <= enc_cur;
      if (wr_en && wr_sel == REG_ENC && |S_AXI_WSTRB) enc_cnt_reg <= '0;
      else enc_cnt_reg <= enc_cnt_reg + enc_delta(enc_prev_reg, enc_cur);
    end
  end

  axi_motor_pwm_gen u_pwm (
    .clk     (ACLK),
    .srst    (ARESET),
    .enable  (ctrl_reg[CTRL_EN_BIT]),
    .brake   (ctrl_reg[CTRL_BRAKE_BIT]),
    .period  (period_reg),
    .duty    (duty_reg),
    .pwm_out (pwm_out)
  );

  assign S_AXI_AWREADY = aw_ready_reg;
  assign S_AXI_WREADY  = aw_ready_reg;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_BVALID  = b_valid_reg;
  assign S_AXI_ARREADY = ar_ready_reg;
  assign S_AXI_RDATA   = r_data_reg;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = r_valid_reg;
  assign dir_out       = ctrl_reg[CTRL_DIR_BIT];
  assign brake_out     = ctrl_reg[CTRL_BRAKE_BIT];

endmodule

// File: tb/tb_axi_motor_lite_slave.sv
// Scoreboard bench for axi_motor_lite_slave: expected read data and write responses
// are queued when a request is issued and compared when the response arrives.
module tb_axi_motor_lite_slave;
  import axi_motor_pkg::*;

  localparam logic [3:0] A_CTRL = 4'h0, A_PERIOD = 4'h4, A_DUTY = 4'h8, A_ENC = 4'hC;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        pwm_out, dir_out, brake_out;

  int          vec_cnt = 0;
  int          miscompare_cnt = 0;
  logic [31:0] rd_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] m_ctrl = '0, m_period = '0, m_duty = '0, m_enc = '0;
  int          gray_idx = 0;
  logic [1:0]  gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  axi_motor_lite_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .enc_a(enc_a), .enc_b(enc_b),
    .pwm_out(pwm_out), .dir_out(dir_out), .brake_out(brake_out)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] addr);
    case (addr[3:2])
      2'd0:    return m_ctrl;
      2'd1:    return m_period;
      2'd2:    return m_duty;
      default: return m_enc;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s);
    case (addr[3:2])
      2'd0:    if (s[0]) m_ctrl = {29'd0, d[2:0]};
      2'd1:    m_period = merge_bytes(m_period, d, s);
      2'd2:    m_duty = merge_bytes(m_duty, d, s);
      default: if (s != 4'd0) m_enc = 32'd0;
    endcase
  endtask

  // All tasks are entered and left on a falling edge.
  task automatic aw_w_send(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    b_q.push_back(RESP_OKAY);
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin ok = 1; break; end
    end
    check_vec("awready_seen", 32'(ok), 32'd1);
    check_vec("wready_with_awready", 32'(S_AXI_WREADY), 32'd1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
  endtask

  task automatic b_wait();
    bit ok = 0;
    logic [1:0] exp;
    for (int i = 0; i < 20; i++) begin
      if (S_AXI_BVALID) begin ok = 1; break; end
      @(negedge ACLK);
    end
    check_vec("bvalid_seen", 32'(ok), 32'd1);
    exp = (b_q.size() > 0) ? b_q.pop_front() : 2'b11;
    check_vec("bresp", 32'(S_AXI_BRESP), 32'(exp));
    @(negedge ACLK);
    if (S_AXI_BREADY) check_vec("bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
  endtask

  task automatic ar_send(input logic [3:0] addr, input logic [31:0] exp);
    bit ok = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    rd_q.push_back(exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) begin ok = 1; break; end
    end
    check_vec("arready_seen", 32'(ok), 32'd1);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
  endtask

  task automatic r_wait(input string tag);
    bit ok = 0;
    logic [31:0] exp;
    for (int i = 0; i < 20; i++) begin
      if (S_AXI_RVALID) begin ok = 1; break; end
      @(negedge ACLK);
    end
    check_vec("rvalid_seen", 32'(ok), 32'd1);
    exp = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
    check_vec(tag, S_AXI_RDATA, exp);
    check_vec("rresp", 32'(S_AXI_RRESP), 32'(RESP_OKAY));
    @(negedge ACLK);
    if (S_AXI_RREADY) check_vec("rvalid_drop", 32'(S_AXI_RVALID), 32'd0);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s);
    S_AXI_BREADY = 1'b1;
    aw_w_send(addr, d, s);
    b_wait();
    model_write(addr, d, s);
  endtask

  task automatic axi_read(input logic [3:0] addr, input string tag);
    S_AXI_RREADY = 1'b1;
    ar_send(addr, model_rd(addr));
    r_wait(tag);
  endtask

  task automatic enc_step(input int dir, input bit settle);
    gray_idx = (gray_idx + dir + 4) % 4;
    {enc_a, enc_b} = gray_seq[gray_idx];
    m_enc = m_enc + ((dir > 0) ? 32'd1 : 32'hFFFF_FFFF);
    if (settle) repeat (4) @(negedge ACLK);
  endtask

  task automatic pwm_highs(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      if (pwm_out) highs++;
    end
  endtask

  initial begin
    int highs;
    repeat (3) @(negedge ACLK);
    check_vec("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check_vec("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check_vec("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check_vec("rst_rdata", S_AXI_RDATA, 32'd0);
    check_vec("rst_pins", {29'd0, pwm_out, dir_out, brake_out}, 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // Register map write/readback; ENC write clears.
    axi_write(A_CTRL, 32'h1, 4'hF);
    axi_write(A_PERIOD, 32'h2, 4'hF);
    axi_write(A_DUTY, 32'h3, 4'hF);
    axi_write(A_ENC, 32'h4, 4'hF);
    axi_read(A_CTRL, "rd_ctrl");
    axi_read(A_PERIOD, "rd_period");
    axi_read(A_DUTY, "rd_duty");
    axi_read(A_ENC, "rd_enc_cleared");
    axi_write(A_CTRL, 32'hFFFF_FFF8, 4'hF);
    axi_read(A_CTRL, "rd_ctrl_upper_zero");

    // Byte strobes.
    axi_write(A_PERIOD, 32'h0, 4'hF);
    axi_write(A_PERIOD, 32'hAABB_CCDD, 4'b0010);
    axi_read(A_PERIOD, "rd_period_strb");
    check_vec("model_period_strb", m_period, 32'h0000_CC00);

    // PWM duty patterns over 50-cycle windows (5 full periods).
    axi_write(A_PERIOD, 32'd10, 4'hF);
    axi_write(A_DUTY, 32'd3, 4'hF);
    axi_write(A_CTRL, 32'h1, 4'hF);
    repeat (15) @(negedge ACLK);
    pwm_highs(50, highs);
    check_vec("pwm_duty3", 32'(highs), 32'd15);
    axi_write(A_DUTY, 32'd0, 4'hF);
    repeat (15) @(negedge ACLK);
    pwm_highs(50, highs);
    check_vec("pwm_duty0", 32'(highs), 32'd0);
    axi_write(A_DUTY, 32'd12, 4'hF);
    repeat (15) @(negedge ACLK);
    pwm_highs(50, highs);
    check_vec("pwm_duty12", 32'(highs), 32'd50);
    axi_write(A_CTRL, 32'h7, 4'hF);
    repeat (3) @(negedge ACLK);
    pwm_highs(20, highs);
    check_vec("pwm_brake", 32'(highs), 32'd0);
    check_vec("dir_brake_pins", {30'd0, dir_out, brake_out}, 32'h3);
    axi_write(A_CTRL, 32'h0, 4'hF);
    repeat (3) @(negedge ACLK);
    pwm_highs(20, highs);
    check_vec("pwm_disabled", 32'(highs), 32'd0);

    // Encoder: 8 forward, 3 reverse.
    for (int i = 0; i < 8; i++) enc_step(1, 1);
    for (int i = 0; i < 3; i++) enc_step(-1, 1);
    axi_read(A_ENC, "rd_enc_5");
    check_vec("model_enc_5", m_enc, 32'd5);

    // Read of ENC and clear on the same edge: read returns the old count.
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    fork
      aw_w_send(A_ENC, 32'h0, 4'hF);
      ar_send(A_ENC, m_enc);
    join
    fork
      b_wait();
      r_wait("rd_enc_pre_clear");
    join
    model_write(A_ENC, 32'h0, 4'hF);
    axi_read(A_ENC, "rd_enc_after_clear");
    enc_step(-1, 1);
    axi_read(A_ENC, "rd_enc_minus1");

    // Clear lands on the same edge as an encoder step.
    enc_step(1, 0);
    @(negedge ACLK);
    axi_write(A_ENC, 32'h0, 4'h1);
    repeat (4) @(negedge ACLK);
    axi_read(A_ENC, "rd_enc_clear_wins");

    // BREADY held low: BVALID held and a queued write is not accepted.
    S_AXI_BREADY = 1'b0;
    aw_w_send(A_PERIOD, 32'h55, 4'hF);
    S_AXI_AWADDR = A_DUTY; S_AXI_WDATA = 32'h66; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check_vec("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
      check_vec("no_second_awready", 32'(S_AXI_AWREADY), 32'd0);
    end
    S_AXI_BREADY = 1'b1;
    b_wait();
    model_write(A_PERIOD, 32'h55, 4'hF);
    aw_w_send(A_DUTY, 32'h66, 4'hF);
    b_wait();
    model_write(A_DUTY, 32'h66, 4'hF);
    axi_read(A_PERIOD, "rd_period_55");

    // RREADY held low: RVALID and RDATA stay stable.
    S_AXI_RREADY = 1'b0;
    ar_send(A_DUTY, m_duty);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check_vec("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
      check_vec("rdata_hold", S_AXI_RDATA, m_duty);
    end
    S_AXI_RREADY = 1'b1;
    r_wait("rd_duty_66");

    // AW before W: nothing accepted until both are valid.
    S_AXI_AWADDR = A_CTRL; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check_vec("aw_only_no_ready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd0);
    end
    axi_write(A_CTRL, 32'h4, 4'hF);
    axi_read(A_CTRL, "rd_ctrl_4");

    // Reset in the middle of PWM activity with a read response pending.
    axi_write(A_PERIOD, 32'd10, 4'hF);
    axi_write(A_DUTY, 32'd12, 4'hF);
    axi_write(A_CTRL, 32'h3, 4'hF);
    repeat (15) @(negedge ACLK);
    check_vec("pwm_before_rst", {30'd0, pwm_out, dir_out}, 32'h3);
    S_AXI_RREADY = 1'b0;
    ar_send(A_CTRL, m_ctrl);
    check_vec("rvalid_before_rst", 32'(S_AXI_RVALID), 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check_vec("rst_mid_pins", {29'd0, pwm_out, dir_out, brake_out}, 32'd0);
    check_vec("rst_mid_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check_vec("rst_mid_rdata", S_AXI_RDATA, 32'd0);
    rd_q.delete();
    b_q.delete();
    m_ctrl = '0; m_period = '0; m_duty = '0; m_enc = '0;
    ARESET = 1'b0;
    @(negedge ACLK);
    axi_read(A_CTRL, "rd_ctrl_after_rst");
    axi_read(A_PERIOD, "rd_period_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
